// File: rtl/cga_regs_v2.sv
// rtl/cga_regs_v2.sv - CGA/Tandy I/O registers, status readback, blink timing and ISA wait states
module cga_regs_v2 #(
  parameter logic [15:0] IO_BASE       = 16'h3D0,
  parameter int          NUM_TREG      = 8,
  parameter int          CURSOR_FRAMES = 8,
  parameter int          CHAR_FRAMES   = 16,
  parameter int          SYNC_STAGES   = 2,
  parameter logic [7:0]  RESET_CTRL    = 8'h29,
  parameter bit          USE_BUS_WAIT  = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [14:0] bus_a,
  input  logic [7:0]  bus_d,
  input  logic        bus_ior_l,
  input  logic        bus_iow_l,
  input  logic        bus_memr_l,
  input  logic        bus_memw_l,
  input  logic        bus_aen,
  input  logic        mem_cs,
  input  logic        cpu_slot,
  input  logic [7:0]  crtc_rd_data,
  input  logic        vsync,
  input  logic        display_enable,
  input  logic        blink_freeze,
  output logic [7:0]  bus_out,
  output logic        bus_dir,
  output logic        bus_rdy,
  output logic        crtc_cs,
  output logic [7:0]  mode_ctrl,
  output logic [7:0]  color_sel,
  output logic [4:0]  tandy_mode,
  output logic [3:0]  tandy_border,
  output logic        palette_we,
  output logic [3:0]  palette_idx,
  output logic [3:0]  palette_data,
  output logic        cursor_blink,
  output logic        char_blink
);

  localparam logic [14:0] BASE      = IO_BASE[14:0];
  localparam logic [14:0] ADDR_CTRL = BASE + 15'd8;
  localparam logic [14:0] ADDR_COL  = BASE + 15'd9;
  localparam logic [14:0] ADDR_STAT = BASE + 15'd10;
  localparam logic [14:0] ADDR_TDAT = BASE + 15'd14;
  localparam logic [4:0]  NT        = 5'(NUM_TREG);
  localparam int          CB        = $clog2(CURSOR_FRAMES);
  localparam int          HB        = $clog2(CHAR_FRAMES);
  localparam int          FW        = HB + 1;

  logic io_ok, ctrl_hit, col_hit, status_cs, tdat_hit;

  assign io_ok     = ~bus_aen;
  assign crtc_cs   = io_ok & (bus_a[14:3] == BASE[14:3]);
  assign ctrl_hit  = io_ok & (bus_a == ADDR_CTRL);
  assign col_hit   = io_ok & (bus_a == ADDR_COL);
  assign status_cs = io_ok & (bus_a == ADDR_STAT);
  assign tdat_hit  = io_ok & (bus_a == ADDR_TDAT);

  // Top bit holds the previous synchronised value for falling-edge detection.
  logic [SYNC_STAGES:0] iow_sync;
  logic                 wr_stb;

  always_ff @(posedge clk) begin
    if (reset) iow_sync <= '1;
    else       iow_sync <= {iow_sync[SYNC_STAGES-1:0], bus_iow_l};
  end

  assign wr_stb = iow_sync[SYNC_STAGES] & ~iow_sync[SYNC_STAGES-1];

  logic [4:0] index_q;
  logic [7:0] treg [NUM_TREG];
  logic       treg_ok;

  assign treg_ok = ~index_q[4] & ({1'b0, index_q[3:0]} < NT);

  always_ff @(posedge clk) begin
    if (reset) begin
      mode_ctrl    <= RESET_CTRL;
      color_sel    <= 8'h00;
      index_q      <= 5'd0;
      palette_we   <= 1'b0;
      palette_idx  <= 4'd0;
      palette_data <= 4'd0;
      for (int i = 0; i < NUM_TREG; i++) treg[i] <= 8'h00;
    end else begin
      palette_we <= 1'b0;
      if (wr_stb) begin
        if (ctrl_hit)  mode_ctrl <= bus_d;
        if (col_hit)   color_sel <= bus_d;
        if (status_cs) index_q   <= bus_d[4:0];
        if (tdat_hit && index_q[4]) begin
          palette_we   <= 1'b1;
          palette_idx  <= index_q[3:0];
          palette_data <= bus_d[3:0];
        end
        if (tdat_hit && treg_ok) begin
          for (int i = 0; i < NUM_TREG; i++)
            if (index_q[3:0] == 4'(i)) treg[i] <= bus_d;
        end
      end
    end
  end

  assign tandy_mode   = treg[3][4:0];
  assign tandy_border = treg[2][3:0];

  logic vs_r, vs_d, de_r;
  logic [FW-1:0] frame_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      vs_r      <= 1'b0;
      vs_d      <= 1'b0;
      de_r      <= 1'b0;
      frame_cnt <= '0;
    end else begin
      vs_r <= vsync;
      vs_d <= vs_r;
      de_r <= display_enable;
      if (vs_r && !vs_d && !blink_freeze) frame_cnt <= frame_cnt + 1'b1;
    end
  end

  assign cursor_blink = frame_cnt[CB];
  assign char_blink   = frame_cnt[HB];

  assign bus_dir = (crtc_cs | status_cs) & ~bus_ior_l;

  always_comb begin
    bus_out = 8'h00;
    if (status_cs && !bus_ior_l)
      bus_out = {4'b1111, vs_r, 2'b10, ~de_r};
    else if (crtc_cs && bus_a[0] && !bus_ior_l)
      bus_out = crtc_rd_data;
  end

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} wait_state_t;
  wait_state_t state;
  logic        rdy_q, access;

  assign access = mem_cs & (~bus_memr_l | ~bus_memw_l);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      rdy_q <= 1'b1;
    end else begin
      case (state)
        S_IDLE: if (access) begin
          state <= S_WAIT;
          rdy_q <= 1'b0;
        end
        S_WAIT: if (!access) begin
          state <= S_IDLE;
          rdy_q <= 1'b1;
        end else if (cpu_slot) begin
          state <= S_DONE;
          rdy_q <= 1'b1;
        end
        S_DONE: if (!access) state <= S_IDLE;
        default: begin
          state <= S_IDLE;
          rdy_q <= 1'b1;
        end
      endcase
    end
  end

  assign bus_rdy = USE_BUS_WAIT ? rdy_q : 1'b1;

endmodule

// File: tb/tb_cga_regs_v2.sv
// tb/tb_cga_regs_v2.sv - directed self-checking bench for cga_regs_v2
module tb_cga_regs_v2;

  localparam logic [14:0] B = 15'h3D0;

  logic        clk, reset;
  logic [14:0] bus_a;
  logic [7:0]  bus_d, crtc_rd_data;
  logic        bus_ior_l, bus_iow_l, bus_memr_l, bus_memw_l, bus_aen;
  logic        mem_cs, cpu_slot, vsync, display_enable, blink_freeze;
  logic [7:0]  bus_out, mode_ctrl, color_sel;
  logic        bus_dir, bus_rdy, crtc_cs, palette_we, cursor_blink, char_blink;
  logic [4:0]  tandy_mode;
  logic [3:0]  tandy_border, palette_idx, palette_data;

  int checks = 0;
  int errors = 0;

  cga_regs_v2 #(.USE_BUS_WAIT(1'b1)) dut (
    .clk(clk), .reset(reset), .bus_a(bus_a), .bus_d(bus_d),
    .bus_ior_l(bus_ior_l), .bus_iow_l(bus_iow_l), .bus_memr_l(bus_memr_l), .bus_memw_l(bus_memw_l),
    .bus_aen(bus_aen), .mem_cs(mem_cs), .cpu_slot(cpu_slot), .crtc_rd_data(crtc_rd_data),
    .vsync(vsync), .display_enable(display_enable), .blink_freeze(blink_freeze),
    .bus_out(bus_out), .bus_dir(bus_dir), .bus_rdy(bus_rdy), .crtc_cs(crtc_cs),
    .mode_ctrl(mode_ctrl), .color_sel(color_sel), .tandy_mode(tandy_mode), .tandy_border(tandy_border),
    .palette_we(palette_we), .palette_idx(palette_idx), .palette_data(palette_data),
    .cursor_blink(cursor_blink), .char_blink(char_blink)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic io_write(input logic [14:0] a, input logic [7:0] d, output int pulses);
    pulses = 0;
    @(negedge clk);
    bus_a = a; bus_d = d; bus_iow_l = 1'b0;
    repeat (5) begin @(negedge clk); if (palette_we) pulses++; end
    bus_iow_l = 1'b1;
    repeat (4) begin @(negedge clk); if (palette_we) pulses++; end
  endtask

  task automatic vsync_pulse();
    @(negedge clk); vsync = 1'b1;
    @(negedge clk); vsync = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk); reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (mode_ctrl !== 8'h29) begin errors++; $display("FAIL rst_mode got %h exp 29", mode_ctrl); end
    checks++; if (color_sel !== 8'h00) begin errors++; $display("FAIL rst_color got %h exp 00", color_sel); end
    checks++; if (bus_rdy !== 1'b1) begin errors++; $display("FAIL rst_rdy got %b exp 1", bus_rdy); end
    checks++; if ({cursor_blink, char_blink} !== 2'b00) begin errors++; $display("FAIL rst_blink got %b exp 00", {cursor_blink, char_blink}); end
    checks++; if ({palette_we, tandy_mode, tandy_border} !== 10'd0) begin errors++; $display("FAIL rst_tandy got %h exp 0", {palette_we, tandy_mode, tandy_border}); end
  endtask

  task automatic test_status();
    @(negedge clk);
    bus_a = B + 15'd10; vsync = 1'b1; display_enable = 1'b0; bus_ior_l = 1'b0;
    #1;
    checks++; if (bus_out !== 8'hF5) begin errors++; $display("FAIL stat_pre got %h exp F5", bus_out); end
    @(negedge clk);
    checks++; if (bus_out !== 8'hFD) begin errors++; $display("FAIL stat_vs got %h exp FD", bus_out); end
    checks++; if (bus_dir !== 1'b1) begin errors++; $display("FAIL stat_dir got %b exp 1", bus_dir); end
    display_enable = 1'b1;
    @(negedge clk);
    checks++; if (bus_out !== 8'hFC) begin errors++; $display("FAIL stat_de got %h exp FC", bus_out); end
    bus_a = B + 15'd1; crtc_rd_data = 8'h5A;
    #1;
    checks++; if (bus_out !== 8'h5A) begin errors++; $display("FAIL crtc_rd got %h exp 5A", bus_out); end
    bus_a = B; #1;
    checks++; if ({bus_out, bus_dir, crtc_cs} !== 10'h003) begin errors++; $display("FAIL crtc_even got %h exp 003", {bus_out, bus_dir, crtc_cs}); end
    bus_a = B + 15'd8; #1;
    checks++; if (bus_dir !== 1'b0) begin errors++; $display("FAIL ctrl_dir got %b exp 0", bus_dir); end
    bus_ior_l = 1'b1; vsync = 1'b0; display_enable = 1'b0;
  endtask

  task automatic test_edge_write();
    int p;
    @(negedge clk);
    bus_a = B + 15'd8; bus_d = 8'h1A; bus_iow_l = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++; if (mode_ctrl !== 8'h29) begin errors++; $display("FAIL wr_early got %h exp 29", mode_ctrl); end
    @(negedge clk);
    checks++; if (mode_ctrl !== 8'h1A) begin errors++; $display("FAIL wr_commit got %h exp 1A", mode_ctrl); end
    bus_d = 8'h33;
    repeat (7) @(negedge clk);
    checks++; if (mode_ctrl !== 8'h1A) begin errors++; $display("FAIL wr_once got %h exp 1A", mode_ctrl); end
    bus_iow_l = 1'b1;
    repeat (3) @(negedge clk);
    bus_aen = 1'b1;
    io_write(B + 15'd9, 8'h55, p);
    checks++; if (color_sel !== 8'h00) begin errors++; $display("FAIL wr_aen got %h exp 00", color_sel); end
    bus_aen = 1'b0;
    io_write(B + 15'd9, 8'h55, p);
    checks++; if (color_sel !== 8'h55) begin errors++; $display("FAIL wr_color got %h exp 55", color_sel); end
  endtask

  task automatic test_tandy();
    int p;
    io_write(B + 15'd10, 8'h13, p);
    io_write(B + 15'd14, 8'h0C, p);
    checks++; if (p !== 1) begin errors++; $display("FAIL pal_pulses got %0d exp 1", p); end
    checks++; if ({palette_idx, palette_data} !== 8'h3C) begin errors++; $display("FAIL pal_data got %h exp 3C", {palette_idx, palette_data}); end
    io_write(B + 15'd10, 8'h02, p);
    io_write(B + 15'd14, 8'h05, p);
    checks++; if ({p[1:0], tandy_border} !== 6'h05) begin errors++; $display("FAIL border got %h exp 05", {p[1:0], tandy_border}); end
    io_write(B + 15'd10, 8'h03, p);
    io_write(B + 15'd14, 8'h1F, p);
    checks++; if (tandy_mode !== 5'h1F) begin errors++; $display("FAIL tmode got %h exp 1F", tandy_mode); end
    io_write(B + 15'd14, 8'h15, p);
    checks++; if (tandy_mode !== 5'h15) begin errors++; $display("FAIL idx_persist got %h exp 15", tandy_mode); end
    io_write(B + 15'd10, 8'h09, p);
    io_write(B + 15'd14, 8'h0A, p);
    checks++; if ({p[1:0], tandy_mode, tandy_border} !== {2'd0, 5'h15, 4'h5}) begin errors++; $display("FAIL idx_oor got %h exp %h", {p[1:0], tandy_mode, tandy_border}, {2'd0, 5'h15, 4'h5}); end
  endtask

  task automatic test_blink();
    do_reset();
    repeat (7) vsync_pulse();
    @(negedge clk); vsync = 1'b1;
    @(negedge clk); vsync = 1'b0;
    checks++; if (cursor_blink !== 1'b0) begin errors++; $display("FAIL blink_lat1 got %b exp 0", cursor_blink); end
    @(negedge clk);
    checks++; if ({cursor_blink, char_blink} !== 2'b10) begin errors++; $display("FAIL blink8 got %b exp 10", {cursor_blink, char_blink}); end
    repeat (8) vsync_pulse();
    checks++; if ({cursor_blink, char_blink} !== 2'b01) begin errors++; $display("FAIL blink16 got %b exp 01", {cursor_blink, char_blink}); end
    blink_freeze = 1'b1;
    repeat (8) vsync_pulse();
    blink_freeze = 1'b0;
    checks++; if ({cursor_blink, char_blink} !== 2'b01) begin errors++; $display("FAIL blink_freeze got %b exp 01", {cursor_blink, char_blink}); end
    repeat (16) vsync_pulse();
    checks++; if ({cursor_blink, char_blink} !== 2'b00) begin errors++; $display("FAIL blink_wrap got %b exp 00", {cursor_blink, char_blink}); end
  endtask

  task automatic test_wait();
    @(negedge clk); mem_cs = 1'b1; bus_memr_l = 1'b0; cpu_slot = 1'b1;
    @(negedge clk); cpu_slot = 1'b0;
    checks++; if (bus_rdy !== 1'b0) begin errors++; $display("FAIL wait_fall got %b exp 0", bus_rdy); end
    @(negedge clk);
    checks++; if (bus_rdy !== 1'b0) begin errors++; $display("FAIL wait_hold got %b exp 0", bus_rdy); end
    cpu_slot = 1'b1;
    @(negedge clk); cpu_slot = 1'b0;
    checks++; if (bus_rdy !== 1'b1) begin errors++; $display("FAIL wait_rise got %b exp 1", bus_rdy); end
    @(negedge clk);
    checks++; if (bus_rdy !== 1'b1) begin errors++; $display("FAIL done_hold got %b exp 1", bus_rdy); end
    bus_memr_l = 1'b1;
    @(negedge clk); bus_memr_l = 1'b0;
    @(negedge clk);
    checks++; if (bus_rdy !== 1'b0) begin errors++; $display("FAIL reenter got %b exp 0", bus_rdy); end
    bus_memr_l = 1'b1;
    @(negedge clk);
    checks++; if (bus_rdy !== 1'b1) begin errors++; $display("FAIL abort got %b exp 1", bus_rdy); end
    bus_memw_l = 1'b0;
    @(negedge clk);
    checks++; if (bus_rdy !== 1'b0) begin errors++; $display("FAIL memw_wait got %b exp 0", bus_rdy); end
    mem_cs = 1'b0; bus_memw_l = 1'b1;
    @(negedge clk);
    checks++; if (bus_rdy !== 1'b1) begin errors++; $display("FAIL cs_drop got %b exp 1", bus_rdy); end
  endtask

  task automatic test_reset_abort();
    @(negedge clk);
    bus_a = B + 15'd8; bus_d = 8'h77; bus_iow_l = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1; bus_iow_l = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    checks++; if (mode_ctrl !== 8'h29) begin errors++; $display("FAIL rst_abort got %h exp 29", mode_ctrl); end
  endtask

  initial begin
    reset = 1'b1; bus_a = '0; bus_d = '0; crtc_rd_data = '0;
    bus_ior_l = 1'b1; bus_iow_l = 1'b1; bus_memr_l = 1'b1; bus_memw_l = 1'b1;
    bus_aen = 1'b0; mem_cs = 1'b0; cpu_slot = 1'b0;
    vsync = 1'b0; display_enable = 1'b0; blink_freeze = 1'b0;
    test_reset();
    test_status();
    test_edge_write();
    test_tandy();
    test_blink();
    test_wait();
    test_reset_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
